// File: rtl/elevator_pkg.sv
// Shared definitions for the SCAN elevator controller.
// State codes and pending-bitmap search helpers.
package elevator_pkg;

    localparam int STATE_W    = 2;
    localparam int MAX_FLOORS = 16;

    localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] ST_DOOR_OPEN = 2'd1;
    localparam logic [STATE_W-1:0] ST_MOVE_UP   = 2'd2;
    localparam logic [STATE_W-1:0] ST_MOVE_DOWN = 2'd3;

    function automatic logic [MAX_FLOORS-1:0] onehot(input int unsigned f);
        return MAX_FLOORS'(1) << f;
    endfunction

    function automatic logic any_above(
        input logic [MAX_FLOORS-1:0] p,
        input int unsigned           f
    );
        return |(p >> (f + 1));
    endfunction

    function automatic logic any_below(
        input logic [MAX_FLOORS-1:0] p,
        input int unsigned           f
    );
        logic [MAX_FLOORS-1:0] mask;
        mask = (MAX_FLOORS'(1) << f) - MAX_FLOORS'(1);
        return |(p & mask);
    endfunction

endpackage

// File: rtl/elevator_phase_timer.sv
// Phase counter: counts 0..last_i while enabled, wraps at terminal count.
// Held at zero when disabled or cleared.
module elevator_phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_o = en_i && (cnt_q == last_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i || !en_i || tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Multi-request SCAN elevator controller with timed door phase.
// Calls latch into a pending bitmap; served in travel direction first.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_W     = 4,
    parameter int STEP_CYCLES = 10000000,
    parameter int DOOR_CYCLES = 20000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [STATE_W-1:0]    state,
    output logic                  door_open,
    output logic                  dir_up
);

    localparam int MAXC  = (STEP_CYCLES > DOOR_CYCLES) ? STEP_CYCLES : DOOR_CYCLES;
    localparam int CNT_W = $clog2(MAXC);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic                  dir_q, dir_d;

    logic [MAX_FLOORS-1:0] pend_ext, set_mask, clr_mask;
    logic [FLOOR_W-1:0]    floor_up, floor_dn;
    logic                  hit_cur, hit_up, hit_dn, above, below;
    logic [STATE_W-1:0]    dec_state;
    logic                  dec_dir;
    logic                  tmr_tc, tmr_en, tmr_clr;
    logic [CNT_W-1:0]      tmr_last;

    assign pend_ext = MAX_FLOORS'(pend_q);
    assign floor_up = floor_q + FLOOR_W'(1);
    assign floor_dn = floor_q - FLOOR_W'(1);
    assign hit_cur  = |(pend_ext & onehot(32'(floor_q)));
    assign hit_up   = |(pend_ext & onehot(32'(floor_up)));
    assign hit_dn   = |(pend_ext & onehot(32'(floor_dn)));
    assign above    = any_above(pend_ext, 32'(floor_q));
    assign below    = any_below(pend_ext, 32'(floor_q));

    assign set_mask = (req_valid && (32'(req_floor) < NUM_FLOORS))
                    ? onehot(32'(req_floor)) : '0;

    // SCAN decision on registered state
    always_comb begin
        dec_state = ST_IDLE;
        dec_dir   = dir_q;
        if (hit_cur) begin
            dec_state = ST_DOOR_OPEN;
        end else if (above && (dir_q || !below)) begin
            dec_state = ST_MOVE_UP;
            dec_dir   = 1'b1;
        end else if (below) begin
            dec_state = ST_MOVE_DOWN;
            dec_dir   = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                state_d  = dec_state;
                dir_d    = dec_dir;
                clr_mask = hit_cur ? onehot(32'(floor_q)) : '0;
            end
            ST_DOOR_OPEN: begin
                if (tmr_tc) begin
                    state_d  = dec_state;
                    dir_d    = dec_dir;
                    clr_mask = hit_cur ? onehot(32'(floor_q)) : '0;
                end
            end
            ST_MOVE_UP: begin
                if (tmr_tc) begin
                    floor_d = floor_up;
                    if (hit_up) begin
                        state_d  = ST_DOOR_OPEN;
                        clr_mask = onehot(32'(floor_up));
                    end
                end
            end
            default: begin
                if (tmr_tc) begin
                    floor_d = floor_dn;
                    if (hit_dn) begin
                        state_d  = ST_DOOR_OPEN;
                        clr_mask = onehot(32'(floor_dn));
                    end
                end
            end
        endcase
        // a clear beats a same-edge set: the opening door serves that call
        pend_d = NUM_FLOORS'((pend_ext | set_mask) & ~clr_mask);
    end

    assign tmr_en   = (state_q != ST_IDLE);
    assign tmr_clr  = (state_d != state_q);
    assign tmr_last = (state_q == ST_DOOR_OPEN) ? CNT_W'(DOOR_CYCLES - 1)
                                                : CNT_W'(STEP_CYCLES - 1);

    elevator_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en_i  (tmr_en),
        .clr_i (tmr_clr),
        .last_i(tmr_last),
        .tc_o  (tmr_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            floor_q <= '0;
            pend_q  <= '0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && tmr_tc) begin
            assert (!(state_q == ST_MOVE_UP &&
                      floor_q == FLOOR_W'(NUM_FLOORS - 1)))
                else $error("car stepped above top floor");
            assert (!(state_q == ST_MOVE_DOWN && floor_q == '0))
                else $error("car stepped below floor 0");
        end
    end
`endif

    assign pending       = pend_q;
    assign current_floor = floor_q;
    assign state         = state_q;
    assign dir_up        = dir_q;
    assign door_open     = (state_q == ST_DOOR_OPEN);

endmodule
